// File: rtl/wb_block_master.sv
// Wishbone classic initiator: one block command becomes a run of single-word reads or writes.
// stb rises the cycle after the command (read) or write word; stalls in FETCH/PUSH follow wdat/rdat valid-ready.
module wb_block_master #(
  parameter int LEN_W   = 8,
  parameter int TIMEOUT = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [31:0]      cmd_addr,
  input  logic [LEN_W-1:0] cmd_len,
  input  logic             wdat_valid,
  output logic             wdat_ready,
  input  logic [31:0]      wdat,
  output logic             rdat_valid,
  input  logic             rdat_ready,
  output logic [31:0]      rdat,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic [31:0]      wbm_dat_i,
  input  logic             wbm_ack_i
);

  localparam int CNT_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_BUS,
    S_PUSH,
    S_FIN
  } state_t;

  state_t             state;
  state_t             state_nx;
  logic               we_q;
  logic [LEN_W-1:0]   remain;
  logic [CNT_W-1:0]   tmo_cnt;
  logic               tmo_hit;
  logic               last_word;
  logic               addr_lsb_unused;

  assign addr_lsb_unused = ^cmd_addr[1:0];
  assign tmo_hit   = (tmo_cnt == CNT_W'(TIMEOUT - 1));
  assign last_word = (remain == LEN_W'(1));

  assign cmd_ready  = (state == S_IDLE);
  assign busy       = (state != S_IDLE);
  assign wdat_ready = (state == S_FETCH);
  assign rdat_valid = (state == S_PUSH);
  assign wbm_cyc_o  = (state == S_BUS);
  assign wbm_stb_o  = (state == S_BUS);
  assign wbm_we_o   = (state == S_BUS) && we_q;
  assign wbm_sel_o  = (state == S_BUS) ? 4'hF : 4'h0;

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          if (cmd_len == '0) state_nx = S_FIN;
          else if (cmd_we)   state_nx = S_FETCH;
          else               state_nx = S_BUS;
        end
      end
      S_FETCH: begin
        if (wdat_valid) state_nx = S_BUS;
      end
      S_BUS: begin
        // ack wins over a timeout landing on the same cycle
        if (wbm_ack_i) begin
          if (!we_q)          state_nx = S_PUSH;
          else if (last_word) state_nx = S_FIN;
          else                state_nx = S_FETCH;
        end else if (tmo_hit) begin
          state_nx = S_FIN;
        end
      end
      S_PUSH: begin
        if (rdat_ready) state_nx = (remain == '0) ? S_FIN : S_BUS;
      end
      S_FIN:   state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      we_q      <= 1'b0;
      remain    <= '0;
      tmo_cnt   <= '0;
      done      <= 1'b0;
      err       <= 1'b0;
      rdat      <= '0;
      wbm_adr_o <= '0;
      wbm_dat_o <= '0;
    end else begin
      done    <= (state == S_FIN);
      tmo_cnt <= '0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            we_q      <= cmd_we;
            wbm_adr_o <= {cmd_addr[31:2], 2'b00};
            remain    <= cmd_len;
            err       <= 1'b0;
          end
        end
        S_FETCH: begin
          if (wdat_valid) wbm_dat_o <= wdat;
        end
        S_BUS: begin
          if (wbm_ack_i) begin
            remain    <= remain - LEN_W'(1);
            wbm_adr_o <= wbm_adr_o + 32'd4;
            if (!we_q) rdat <= wbm_dat_i;
          end else if (tmo_hit) begin
            err <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
